// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: shared types and constants for the slot controller.
// Contents: controller state enum, input-word bit positions,
//           counter width helper sized for the longer of the two intervals.
package tt_mux_pkg;

    typedef enum logic [1:0] {IDLE, GUARD, PRST, RUN} state_e;

    localparam int IW_CLK_BIT  = 0;
    localparam int IW_RSTN_BIT = 1;

    function automatic int cnt_w(input int guard_cycles, input int rst_cycles);
        return $clog2((guard_cycles > rst_cycles ? guard_cycles : rst_cycles) + 1);
    endfunction

endpackage

// File: rtl/tt_mux_ow_sel.sv
// tt_mux_ow_sel: NUM_PROJ:1 output-word mux with a zero-force input.
// Ports:
//   ow_proj  in   flattened project outputs, slot i at [i*OW_W +: OW_W]
//   sel      in   slot index to forward
//   zero     in   force the output word to 0
//   ow       out  selected (or zeroed) output word
module tt_mux_ow_sel #(
    parameter int NUM_PROJ = 8,
    parameter int OW_W     = 24,
    parameter int SEL_W    = $clog2(NUM_PROJ)
) (
    input  logic [NUM_PROJ*OW_W-1:0] ow_proj,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     zero,
    output logic [OW_W-1:0]          ow
);

    assign ow = zero ? '0 : ow_proj[sel*OW_W +: OW_W];

endmodule

// File: rtl/tt_mux_slot_ctrl.sv
// tt_mux_slot_ctrl: multi-project slot controller for the shared-pad multiplexer.
// On every accepted select it runs a guard interval (all ena low), then holds the
// new project in reset, then lets it run; only the running project reaches the pads.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sel_valid/sel_ready select request handshake, sel_addr = requested slot
//   sel_err             one-cycle pulse when an out-of-range slot is rejected
//   iw_pad / iw_proj    pad input word / word broadcast to all projects
//   ow_proj / ow_pad    flattened project outputs / word returned to the pads
//   ena                 one-hot (or zero) project enable
//   cur_sel             last accepted slot, active = running
// Option: define TT_MUX_OUT_REG_EN to register ow_pad (one cycle of latency).
module tt_mux_slot_ctrl
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ     = 8,
    parameter int IW_W         = 18,
    parameter int OW_W         = 24,
    parameter int GUARD_CYCLES = 4,
    parameter int RST_CYCLES   = 8,
    parameter int SEL_W        = $clog2(NUM_PROJ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_valid,
    output logic                     sel_ready,
    input  logic [SEL_W-1:0]         sel_addr,
    output logic                     sel_err,
    input  logic [IW_W-1:0]          iw_pad,
    output logic [IW_W-1:0]          iw_proj,
    input  logic [NUM_PROJ*OW_W-1:0] ow_proj,
    output logic [OW_W-1:0]          ow_pad,
    output logic [NUM_PROJ-1:0]      ena,
    output logic [SEL_W-1:0]         cur_sel,
    output logic                     active
);

    localparam int CW = cnt_w(GUARD_CYCLES, RST_CYCLES);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             sel_err_q, sel_err_d;
    logic             take, in_range, ow_zero;
    logic [OW_W-1:0]  ow_mux;

    // Widened by one bit so the range check stays meaningful for power-of-2 NUM_PROJ.
    assign in_range = {1'b0, sel_addr} < (SEL_W+1)'(NUM_PROJ);
    assign take     = sel_valid && sel_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        sel_err_d = 1'b0;
        if (take) begin
            if (in_range) begin
                state_d   = GUARD;
                cnt_d     = CW'(GUARD_CYCLES - 1);
                cur_sel_d = sel_addr;
            end else begin
                sel_err_d = 1'b1;
            end
        end else if (state_q == GUARD || state_q == PRST) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (state_q == GUARD) begin
                state_d = PRST;
                cnt_d   = CW'(RST_CYCLES - 1);
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_sel_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_ready = state_q == IDLE || state_q == RUN;
    assign active    = state_q == RUN;
    assign sel_err   = sel_err_q;
    assign cur_sel   = cur_sel_q;
    // ena derives from registered state, so it drops on the accept edge and resets asynchronously.
    assign ena       = (state_q == PRST || state_q == RUN) ? NUM_PROJ'(1) << cur_sel_q : '0;
    assign iw_proj   = state_q == RUN  ? iw_pad :
                       state_q == PRST ? iw_pad & ~(IW_W'(1) << IW_RSTN_BIT) : '0;

    tt_mux_ow_sel #(
        .NUM_PROJ (NUM_PROJ),
        .OW_W     (OW_W),
        .SEL_W    (SEL_W)
    ) u_ow_sel (
        .ow_proj (ow_proj),
        .sel     (cur_sel_q),
        .zero    (ow_zero),
        .ow      (ow_mux)
    );

`ifdef TT_MUX_OUT_REG_EN
    logic [OW_W-1:0] ow_q;

    // Zeroing on the next state clears the pads on the same edge RUN is left.
    assign ow_zero = state_d != RUN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ow_q <= '0;
        else     ow_q <= ow_mux;
    end

    assign ow_pad = ow_q;
`else
    assign ow_zero = state_q != RUN;
    assign ow_pad  = ow_mux;
`endif

endmodule

// File: tb/tb_tt_mux_slot_ctrl.sv
// tb_tt_mux_slot_ctrl: directed bench for tt_mux_slot_ctrl (8-slot and 6-slot instances).
module tb_tt_mux_slot_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel_valid, sel_ready, sel_err, active;
    logic [2:0]   sel_addr, cur_sel;
    logic [17:0]  iw_pad, iw_proj;
    logic [191:0] ow_proj;
    logic [23:0]  ow_pad;
    logic [7:0]   ena;

    logic         sel_valid6, sel_ready6, sel_err6, active6;
    logic [2:0]   sel_addr6, cur_sel6;
    logic [17:0]  iw_proj6;
    logic [143:0] ow_proj6;
    logic [23:0]  ow_pad6;
    logic [5:0]   ena6;

    int total = 0;
    int bad   = 0;

    tt_mux_slot_ctrl u_dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_ready(sel_ready),
        .sel_addr(sel_addr), .sel_err(sel_err), .iw_pad(iw_pad), .iw_proj(iw_proj),
        .ow_proj(ow_proj), .ow_pad(ow_pad), .ena(ena), .cur_sel(cur_sel), .active(active)
    );

    tt_mux_slot_ctrl #(.NUM_PROJ(6)) u_dut6 (
        .clk(clk), .rst(rst), .sel_valid(sel_valid6), .sel_ready(sel_ready6),
        .sel_addr(sel_addr6), .sel_err(sel_err6), .iw_pad(iw_pad), .iw_proj(iw_proj6),
        .ow_proj(ow_proj6), .ow_pad(ow_pad6), .ena(ena6), .cur_sel(cur_sel6), .active(active6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Entered at the negedge right after an accept edge; leaves at the first RUN negedge.
    task automatic seq(input int s);
        for (int i = 0; i < 4; i++) begin
            chk("grd_ena", ena, 0);
            chk("grd_rdy", sel_ready, 0);
            chk("grd_iw", iw_proj, 0);
            chk("grd_ow", ow_pad, 0);
            chk("grd_sel", cur_sel, s);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            chk("prst_ena", ena, 64'd1 << s);
            chk("prst_rdy", sel_ready, 0);
            chk("prst_iw", iw_proj, iw_pad & 18'h3FFFD);
            chk("prst_act", active, 0);
            chk("prst_ow", ow_pad, 0);
            step();
        end
        chk("run_act", active, 1);
        chk("run_rdy", sel_ready, 1);
        chk("run_ena", ena, 64'd1 << s);
        chk("run_iw", iw_proj, iw_pad);
        chk("run_ow", ow_pad, ow_proj[s*24 +: 24]);
    endtask

    initial begin
        rst        = 1'b1;
        sel_valid  = 1'b0;
        sel_addr   = '0;
        sel_valid6 = 1'b0;
        sel_addr6  = '0;
        iw_pad     = 18'h12347;
        for (int i = 0; i < 8; i++) ow_proj[i*24 +: 24] = 24'h111111 * (i + 1);
        ow_proj[2*24 +: 24] = 24'h000000;
        for (int i = 0; i < 6; i++) ow_proj6[i*24 +: 24] = 24'h0F0F00 + 24'(i);
        repeat (2) step();
        chk("rst_ena", ena, 0);
        chk("rst_sel", cur_sel, 0);
        chk("rst_act", active, 0);
        chk("rst_err", sel_err, 0);
        chk("rst_iw", iw_proj, 0);
        chk("rst_ow", ow_pad, 0);
        rst = 1'b0;
        step();
        chk("idle_rdy", sel_ready, 1);
        chk("idle_ena", ena, 0);

        // 1: select 3 from IDLE (6-slot instance selects 1 alongside)
        sel_valid  = 1'b1; sel_addr  = 3'd3;
        sel_valid6 = 1'b1; sel_addr6 = 3'd1;
        step();
        sel_valid  = 1'b0;
        sel_valid6 = 1'b0;
        seq(3);
        chk("run3_ow", ow_pad, 24'h444444);

        // 4: out-of-range request on the 6-slot instance
        chk("d6_act", active6, 1);
        sel_valid6 = 1'b1; sel_addr6 = 3'd7;
        #1 chk("d6_err_pre", sel_err6, 0);
        step();
        sel_valid6 = 1'b0;
        chk("d6_err", sel_err6, 1);
        chk("d6_ena", ena6, 6'b000010);
        chk("d6_sel", cur_sel6, 1);
        chk("d6_act2", active6, 1);
        step();
        chk("d6_err_off", sel_err6, 0);
        chk("d6_ena2", ena6, 6'b000010);

        // 2+3: select 5 from RUN, then hold a request for 6 through the whole sequence
        sel_valid = 1'b1; sel_addr = 3'd5;
        #1 chk("pre_sw_ow", ow_pad, 24'h444444);
        step();
        sel_addr = 3'd6;
        seq(5);
        step();
        sel_valid = 1'b0;
        seq(6);
        repeat (2) step();
        chk("one_acc_sel", cur_sel, 6);
        chk("one_acc_act", active, 1);
        chk("one_acc_ena", ena, 8'b0100_0000);

        // 6: output-word latency on slot 2
        sel_valid = 1'b1; sel_addr = 3'd2;
        step();
        sel_valid = 1'b0;
        seq(2);
        ow_proj[2*24 +: 24] = 24'hA5A5A5;
`ifdef TT_MUX_OUT_REG_EN
        #1 chk("ow_lat0", ow_pad, 24'h000000);
`else
        #1 chk("ow_lat0", ow_pad, 24'hA5A5A5);
`endif
        step();
        chk("ow_lat1", ow_pad, 24'hA5A5A5);
        rst = 1'b1;
        #1 chk("rrun_ow", ow_pad, 0);
        chk("rrun_act", active, 0);
        chk("rrun_ena", ena, 0);
        step();
        rst = 1'b0;
        step();

        // 5: asynchronous reset in the middle of PRST
        sel_valid = 1'b1; sel_addr = 3'd4;
        step();
        sel_valid = 1'b0;
        repeat (6) step();
        chk("mid_ena", ena, 8'b0001_0000);
        chk("mid_iw", iw_proj, 18'h12345);
        rst = 1'b1;
        #1 chk("ar_ena", ena, 0);
        chk("ar_iw", iw_proj, 0);
        chk("ar_ow", ow_pad, 0);
        chk("ar_act", active, 0);
        chk("ar_sel", cur_sel, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rdy", sel_ready, 1);
        chk("post_ena", ena, 0);
        chk("post_act", active, 0);
        step();
        chk("post_ena2", ena, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
